// File: rtl/ram_dp_arbiter_pkg.sv
// rtl/ram_dp_arbiter_pkg.sv - shared constants and parameter checks for the RAM port arbiter
package ram_dp_arbiter_pkg;

  // Largest requester count the arbiter is built for.
  localparam int MAX_PORTS = 8;

  // Mask polarity: a mask bit equal to this value means the data bit is written.
  localparam bit MASK_WRITE = 1'b1;

  // Grant-index width rule: PortWidth must be able to name every requester.
  function automatic bit port_width_ok(input int num_ports, input int port_width);
    return (num_ports >= 2) && (num_ports <= MAX_PORTS) &&
           (port_width >= 1) && ((1 << port_width) >= num_ports);
  endfunction

endpackage

// File: rtl/ram_dp_arbiter_if.sv
// rtl/ram_dp_arbiter_if.sv - requester and RAM-side signal bundle for ram_dp_arbiter
interface ram_dp_arbiter_if #(
  parameter int NumPorts  = 2,
  parameter int AddrWidth = 10,
  parameter int DataWidth = 8
);
  // Write requests, flat per port: port i at [i*W +: W].
  logic [NumPorts-1:0]           wr_valid;
  logic [NumPorts-1:0]           wr_ready;
  logic [NumPorts*AddrWidth-1:0] wr_addr;
  logic [NumPorts*DataWidth-1:0] wr_data;
  logic [NumPorts*DataWidth-1:0] wr_mask;

  // Read requests and routed responses.
  logic [NumPorts-1:0]           rd_valid;
  logic [NumPorts-1:0]           rd_ready;
  logic [NumPorts*AddrWidth-1:0] rd_addr;
  logic [NumPorts-1:0]           rd_resp_valid;
  logic [DataWidth-1:0]          rd_resp_data;

  // Pins of the shared dual-port RAM.
  logic                          ram_write_en;
  logic [AddrWidth-1:0]          ram_write_addr;
  logic [DataWidth-1:0]          ram_write_data;
  logic [DataWidth-1:0]          ram_write_mask;
  logic                          ram_read_en;
  logic [AddrWidth-1:0]          ram_read_addr;
  logic [DataWidth-1:0]          ram_read_data;

  // Requesters plus the RAM model drive this side.
  modport master (
    output wr_valid, wr_addr, wr_data, wr_mask, rd_valid, rd_addr, ram_read_data,
    input  wr_ready, rd_ready, rd_resp_valid, rd_resp_data,
    input  ram_write_en, ram_write_addr, ram_write_data, ram_write_mask,
    input  ram_read_en, ram_read_addr
  );

  // The arbiter drives this side.
  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_mask, rd_valid, rd_addr, ram_read_data,
    output wr_ready, rd_ready, rd_resp_valid, rd_resp_data,
    output ram_write_en, ram_write_addr, ram_write_data, ram_write_mask,
    output ram_read_en, ram_read_addr
  );
endinterface

// File: rtl/ram_dp_arbiter_rr_arbiter.sv
// rtl/ram_dp_arbiter_rr_arbiter.sv - round-robin grant over NumPorts requests
module ram_dp_arbiter_rr_arbiter #(
  parameter int NumPorts  = 2,
  parameter int PortWidth = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NumPorts-1:0]  i_req,
  input  logic                 i_advance,
  output logic [NumPorts-1:0]  o_grant,
  output logic [PortWidth-1:0] o_grant_idx,
  output logic                 o_any
);

  logic [PortWidth-1:0] r_last;
  int                   w_dist;
  int                   w_best_dist;
  int                   w_best;

  // Pick the requesting port closest after r_last in circular order; nothing wins during reset.
  always_comb begin
    w_dist      = 0;
    w_best_dist = NumPorts;
    w_best      = 0;
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    for (int p = 0; p < NumPorts; p++) begin
      // Distance 0 means p is the port right after r_last.
      w_dist = (p + NumPorts - 1 - int'(r_last)) % NumPorts;
      if (!reset && i_req[p] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_best      = p;
      end
    end
    if (w_best_dist < NumPorts) begin
      o_any       = 1'b1;
      o_grant_idx = PortWidth'(w_best);
      for (int p = 0; p < NumPorts; p++) begin
        o_grant[p] = (p == w_best);
      end
    end
  end

  // Remember the winner only when its transfer actually happened.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= PortWidth'(NumPorts - 1);
    end else if (i_advance) begin
      r_last <= o_grant_idx;
    end
  end

endmodule

// File: rtl/ram_dp_arbiter.sv
// rtl/ram_dp_arbiter.sv - shares one dual-port RAM between NumPorts requesters
module ram_dp_arbiter
  import ram_dp_arbiter_pkg::*;
#(
  parameter int NumPorts  = 2,
  parameter int PortWidth = 1,
  parameter int DataWidth = 8,
  parameter int AddrWidth = 10
) (
  input logic             clk,
  input logic             reset,
  ram_dp_arbiter_if.slave bus
);

  if (!port_width_ok(NumPorts, PortWidth)) begin : g_bad_port_width
    $fatal(1, "ram_dp_arbiter: PortWidth cannot index NumPorts requesters");
  end

  logic [NumPorts-1:0]  w_wr_grant;
  logic [PortWidth-1:0] w_wr_idx;
  logic                 w_wr_any;
  logic [NumPorts-1:0]  w_rd_grant;
  logic [PortWidth-1:0] w_rd_idx;
  logic                 w_rd_any;

  logic [AddrWidth-1:0] w_wr_addr;
  logic [DataWidth-1:0] w_wr_data;
  logic [DataWidth-1:0] w_wr_mask;
  logic [AddrWidth-1:0] w_rd_cand_addr;
  logic                 w_collide;
  logic                 w_rd_fire;
  logic [NumPorts-1:0]  w_resp_valid;

  logic                 r_tag_valid;
  logic [PortWidth-1:0] r_tag_idx;

  // A granted write always completes, so the write arbiter advances on any grant.
  ram_dp_arbiter_rr_arbiter #(
    .NumPorts  (NumPorts),
    .PortWidth (PortWidth)
  ) u_wr_arb (
    .clk         (clk),
    .reset       (reset),
    .i_req       (bus.wr_valid),
    .i_advance   (w_wr_any),
    .o_grant     (w_wr_grant),
    .o_grant_idx (w_wr_idx),
    .o_any       (w_wr_any)
  );

  // The read arbiter holds its position while a collision defers the winner.
  ram_dp_arbiter_rr_arbiter #(
    .NumPorts  (NumPorts),
    .PortWidth (PortWidth)
  ) u_rd_arb (
    .clk         (clk),
    .reset       (reset),
    .i_req       (bus.rd_valid),
    .i_advance   (w_rd_fire),
    .o_grant     (w_rd_grant),
    .o_grant_idx (w_rd_idx),
    .o_any       (w_rd_any)
  );

  // One-hot AND-OR mux of the write winner's fields; all zero when nobody is granted.
  always_comb begin
    w_wr_addr = '0;
    w_wr_data = '0;
    w_wr_mask = '0;
    for (int i = 0; i < NumPorts; i++) begin
      if (w_wr_grant[i]) begin
        w_wr_addr = bus.wr_addr[i*AddrWidth +: AddrWidth];
        w_wr_data = bus.wr_data[i*DataWidth +: DataWidth];
        w_wr_mask = MASK_WRITE ? bus.wr_mask[i*DataWidth +: DataWidth]
                               : ~bus.wr_mask[i*DataWidth +: DataWidth];
      end
    end
  end

  // Read winner's address, needed for the collision compare even when the read is deferred.
  always_comb begin
    w_rd_cand_addr = '0;
    for (int i = 0; i < NumPorts; i++) begin
      if (w_rd_grant[i]) begin
        w_rd_cand_addr = bus.rd_addr[i*AddrWidth +: AddrWidth];
      end
    end
  end

  // Reading an address being written this cycle would return stale data; defer the read instead.
  assign w_collide = w_rd_any && w_wr_any && (w_rd_cand_addr == w_wr_addr);
  assign w_rd_fire = w_rd_any && !w_collide;

  assign bus.wr_ready       = w_wr_grant;
  assign bus.ram_write_en   = w_wr_any;
  assign bus.ram_write_addr = w_wr_addr;
  assign bus.ram_write_data = w_wr_data;
  assign bus.ram_write_mask = w_wr_mask;

  assign bus.rd_ready      = w_rd_fire ? w_rd_grant : '0;
  assign bus.ram_read_en   = w_rd_fire;
  assign bus.ram_read_addr = w_rd_fire ? w_rd_cand_addr : '0;

  // Tag the issued read so next cycle's RAM output is routed to its requester.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag_valid <= 1'b0;
      r_tag_idx   <= '0;
    end else begin
      r_tag_valid <= w_rd_fire;
      if (w_rd_fire) begin
        r_tag_idx <= w_rd_idx;
      end
    end
  end

  // Decode the tag into a one-hot response strobe.
  always_comb begin
    w_resp_valid = '0;
    for (int i = 0; i < NumPorts; i++) begin
      w_resp_valid[i] = r_tag_valid && (r_tag_idx == PortWidth'(i));
    end
  end

  assign bus.rd_resp_valid = w_resp_valid;
  assign bus.rd_resp_data  = bus.ram_read_data;

endmodule

// File: tb/tb_ram_dp_arbiter.sv
// tb/tb_ram_dp_arbiter.sv - directed and randomized check of ram_dp_arbiter against a memory model
module tb_ram_dp_arbiter;
  localparam int NP = 2;
  localparam int PW = 1;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ram_dp_arbiter_if #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW)) bus ();

  ram_dp_arbiter #(
    .NumPorts  (NP),
    .PortWidth (PW),
    .DataWidth (DW),
    .AddrWidth (AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Stand-in for ram_dp: masked write, registered read.
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_write_en)
      ram_mem[bus.ram_write_addr] <= (ram_mem[bus.ram_write_addr] & ~bus.ram_write_mask) |
                                     (bus.ram_write_data & bus.ram_write_mask);
    if (bus.ram_read_en)
      bus.ram_read_data <= ram_mem[bus.ram_read_addr];
  end

  // Reference model state.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_wr_last, m_rd_last;
  bit            m_tag_v;
  int            m_tag_p;
  logic [DW-1:0] m_tag_d;
  bit [NP-1:0]   m_wr_fire, m_rd_fire;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model one cycle from current inputs: check outputs, then apply the edge's effects.
  task automatic model_cycle();
    int wg, rg, p;
    bit col;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd, wm;
    logic [NP-1:0] e_wr, e_rd, e_resp;
    wg = -1; rg = -1; col = 0;
    wa = '0; wd = '0; wm = '0; ra = '0;
    m_wr_fire = '0; m_rd_fire = '0;
    if (reset) begin
      m_wr_last = NP - 1;
      m_rd_last = NP - 1;
      m_tag_v = 0;
    end else begin
      for (int k = 1; k <= NP; k++) begin
        p = (m_wr_last + k) % NP;
        if (wg < 0 && bus.wr_valid[p]) wg = p;
        p = (m_rd_last + k) % NP;
        if (rg < 0 && bus.rd_valid[p]) rg = p;
      end
    end
    if (wg >= 0) begin
      wa = bus.wr_addr[wg*AW +: AW];
      wd = bus.wr_data[wg*DW +: DW];
      wm = bus.wr_mask[wg*DW +: DW];
    end
    if (rg >= 0) begin
      ra = bus.rd_addr[rg*AW +: AW];
      col = (wg >= 0) && (ra == wa);
    end
    e_wr = '0;   if (wg >= 0) e_wr[wg] = 1'b1;
    e_rd = '0;   if (rg >= 0 && !col) e_rd[rg] = 1'b1;
    e_resp = '0; if (m_tag_v) e_resp[m_tag_p] = 1'b1;
    chk("wr_ready", bus.wr_ready, e_wr);
    chk("rd_ready", bus.rd_ready, e_rd);
    chk("ram_write_en", bus.ram_write_en, wg >= 0);
    chk("ram_write_addr", bus.ram_write_addr, wa);
    chk("ram_write_data", bus.ram_write_data, wd);
    chk("ram_write_mask", bus.ram_write_mask, wm);
    chk("ram_read_en", bus.ram_read_en, rg >= 0 && !col);
    chk("ram_read_addr", bus.ram_read_addr, (rg >= 0 && !col) ? ra : '0);
    chk("rd_resp_valid", bus.rd_resp_valid, e_resp);
    if (m_tag_v) chk("rd_resp_data", bus.rd_resp_data, m_tag_d);
    m_tag_v = 0;
    if (rg >= 0 && !col) begin
      m_tag_v = 1; m_tag_p = rg; m_tag_d = m_mem[ra];
      m_rd_last = rg; m_rd_fire[rg] = 1'b1;
    end
    if (wg >= 0) begin
      m_mem[wa] = (m_mem[wa] & ~wm) | (wd & wm);
      m_wr_last = wg; m_wr_fire[wg] = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int p, input bit v, input int a, input int d, input int m);
    bus.wr_valid[p] = v;
    bus.wr_addr[p*AW +: AW] = AW'(a);
    bus.wr_data[p*DW +: DW] = DW'(d);
    bus.wr_mask[p*DW +: DW] = DW'(m);
  endtask

  task automatic set_rd(input int p, input bit v, input int a);
    bus.rd_valid[p] = v;
    bus.rd_addr[p*AW +: AW] = AW'(a);
  endtask

  // New random request for a port whose previous request completed or was idle.
  task automatic rand_port(input int p);
    if (!bus.wr_valid[p] || m_wr_fire[p])
      set_wr(p, $urandom_range(0, 3) != 0, $urandom_range(0, 15),
             $urandom_range(0, 255), $urandom_range(0, 255));
    if (!bus.rd_valid[p] || m_rd_fire[p])
      set_rd(p, $urandom_range(0, 3) != 0, $urandom_range(0, 15));
  endtask

  initial begin
    int n_grant, n_resp;
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = '0;
      m_mem[i] = '0;
    end
    bus.ram_read_data = '0;
    bus.wr_valid = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_mask = '0;
    bus.rd_valid = '0; bus.rd_addr = '0;
    m_wr_last = NP - 1; m_rd_last = NP - 1; m_tag_v = 0; m_tag_p = 0; m_tag_d = '0;
    m_wr_fire = '0; m_rd_fire = '0;

    // Reset state, with requests present to show nothing is granted during reset.
    set_wr(0, 1, 1, 8'h55, 8'hFF);
    set_rd(1, 1, 2);
    #2;
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_rd_ready", bus.rd_ready, 0);
    chk("rst_resp_valid", bus.rd_resp_valid, 0);
    chk("rst_resp_data", bus.rd_resp_data, bus.ram_read_data);
    chk("rst_ram_en", {bus.ram_write_en, bus.ram_read_en}, 0);
    step();
    step();
    bus.wr_valid = '0; bus.rd_valid = '0;
    reset = 1'b0;

    // Both ports write continuously: grants alternate 0,1,0,1.
    set_wr(0, 1, 3, 8'h11, 8'hFF);
    set_wr(1, 1, 4, 8'h22, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wr_alternate", bus.wr_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      step();
    end
    bus.wr_valid = '0;

    // Port 1 reads address 4; response routed to port 1 only.
    set_rd(1, 1, 4);
    #1;
    chk("rd1_ready", bus.rd_ready, 2'b10);
    step();
    bus.rd_valid = '0;
    chk("rd1_resp_valid", bus.rd_resp_valid, 2'b10);
    chk("rd1_resp_data", bus.rd_resp_data, 8'h22);

    // Same-address write and read: read deferred one cycle, then returns the new data.
    set_wr(0, 1, 7, 8'hAB, 8'hFF);
    set_rd(1, 1, 7);
    #1;
    chk("col_rd_ready_first", bus.rd_ready, 2'b00);
    chk("col_wr_ready", bus.wr_ready, 2'b01);
    step();
    bus.wr_valid = '0;
    #1;
    chk("col_rd_ready_retry", bus.rd_ready, 2'b10);
    step();
    bus.rd_valid = '0;
    chk("col_resp_valid", bus.rd_resp_valid, 2'b10);
    chk("col_resp_data", bus.rd_resp_data, 8'hAB);

    // Masked write: 0xFF under mask 0xF0 over 0x00 reads back 0xF0.
    set_wr(0, 1, 20, 8'h00, 8'hFF);
    step();
    set_wr(0, 1, 20, 8'hFF, 8'hF0);
    step();
    bus.wr_valid = '0;
    set_rd(0, 1, 20);
    step();
    bus.rd_valid = '0;
    chk("mask_resp_valid", bus.rd_resp_valid, 2'b01);
    chk("mask_resp_data", bus.rd_resp_data, 8'hF0);

    // Port 0 alone for 5 cycles: 5 grants, 5 responses, then port 1 is next in line.
    n_grant = 0; n_resp = 0;
    set_rd(0, 1, 3);
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.rd_ready == 2'b01) n_grant++;
      step();
      if (bus.rd_resp_valid == 2'b01) n_resp++;
    end
    chk("solo_grants", n_grant, 5);
    chk("solo_resps", n_resp, 5);
    set_rd(1, 1, 4);
    #1;
    chk("solo_then_port1", bus.rd_ready, 2'b10);
    step();
    bus.rd_valid[1] = 1'b0;
    step();
    bus.rd_valid = '0;

    // Reset right after a read grant: the pending response is dropped, arbitration restarts at 0.
    set_rd(1, 1, 4);
    #1;
    chk("pre_rst_rd_ready", bus.rd_ready, 2'b10);
    step();
    bus.rd_valid = '0;
    reset = 1'b1;
    #1;
    chk("rst_drop_resp", bus.rd_resp_valid, 2'b00);
    step();
    reset = 1'b0;
    #1;
    chk("post_rst_resp", bus.rd_resp_valid, 2'b00);
    set_rd(0, 1, 5);
    set_rd(1, 1, 6);
    #1;
    chk("post_rst_grant", bus.rd_ready, 2'b01);
    step();
    bus.rd_valid[0] = 1'b0;
    step();
    bus.rd_valid = '0;
    step();

    // Randomized traffic over a small address window to provoke collisions.
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < NP; p++) rand_port(p);
      step();
    end
    bus.wr_valid = '0;
    bus.rd_valid = '0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
